// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter driving the select/enable of a shared 8:1 mux.
// A per-grant hold limit forces rotation among active requesters.
module mux8_rr_arbiter #(
   parameter int unsigned HOLD_MAX = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] req,
   output logic [2:0] sel,
   output logic       enable,
   output logic [7:0] grant
);

   localparam logic [7:0] LP_HOLD = 8'(HOLD_MAX);

   typedef enum logic {
      IDLE,
      GRANT
   } state_t;

   state_t     r_state;
   logic [2:0] r_owner;
   logic [2:0] r_ptr;
   logic [7:0] r_cnt;

   state_t     w_state;
   logic [2:0] w_owner;
   logic [2:0] w_ptr;
   logic [7:0] w_cnt;
   logic       w_drop;
   logic       w_tmo;
   logic [7:0] w_cand;

   // First set bit of c scanning p+1, p+2, ... with p itself examined last.
   function automatic logic [2:0] f_pick(
      input logic [7:0] c,
      input logic [2:0] p
   );
      logic [2:0] idx;
      logic       found;
      f_pick = p;
      found  = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         idx = p + 3'(i);
         if (!found && c[idx]) begin
            f_pick = idx;
            found  = 1'b1;
         end
      end
   endfunction

   // State register; reset leaves ptr at 7 so index 0 wins first.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_owner <= 3'd0;
         r_ptr   <= 3'd7;
         r_cnt   <= 8'd0;
      end else begin
         r_state <= w_state;
         r_owner <= w_owner;
         r_ptr   <= w_ptr;
         r_cnt   <= w_cnt;
      end
   end

   // Next-state: grant, hold counting, release and back-to-back handover.
   always_comb begin
      w_state = r_state;
      w_owner = r_owner;
      w_ptr   = r_ptr;
      w_cnt   = r_cnt;
      w_drop  = ~req[r_owner];
      w_tmo   = (r_cnt == LP_HOLD);
      w_cand  = req;
      unique case (r_state)
         IDLE: begin
            if (|req) begin
               w_owner = f_pick(req, r_ptr);
               w_cnt   = 8'd1;
               w_state = GRANT;
            end
         end
         GRANT: begin
            if (w_drop || w_tmo) begin
               w_ptr = r_owner;
               if (w_drop) begin
                  w_cand[r_owner] = 1'b0;
               end
               if (|w_cand) begin
                  w_owner = f_pick(w_cand, r_owner);
                  w_cnt   = 8'd1;
               end else begin
                  w_state = IDLE;
                  w_cnt   = 8'd0;
               end
            end else begin
               w_cnt = r_cnt + 8'd1;
            end
         end
         default: begin
            w_state = IDLE;
         end
      endcase
   end

   // Outputs decode purely from registered state.
   assign enable = (r_state == GRANT);
   assign sel    = r_owner;
   assign grant  = enable ? (8'd1 << r_owner) : 8'd0;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Bench for mux8_rr_arbiter: per-cycle vector table with
// hand-derived expectations routed through a scoreboard queue.
module tb_mux8_rr_arbiter;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] req = 8'h00;
   logic [2:0] sel;
   logic       enable;
   logic [7:0] grant;

   int n_chk = 0;
   int n_fail = 0;

   typedef struct {
      int         tid;
      logic       rst_n;
      logic [7:0] req;
      logic [7:0] g;
      logic [2:0] s;
      logic       e;
   } vec_t;

   vec_t vecs[$];
   vec_t exp_q[$];

   always #5 clk = ~clk;

   mux8_rr_arbiter #(.HOLD_MAX(4)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .req    (req),
      .sel    (sel),
      .enable (enable),
      .grant  (grant)
   );

   function automatic void add(
      input int         t,
      input logic       r,
      input logic [7:0] q,
      input logic [7:0] g,
      input logic [2:0] s,
      input logic       e
   );
      vec_t v;
      v.tid = t;
      v.rst_n = r;
      v.req = q;
      v.g = g;
      v.s = s;
      v.e = e;
      vecs.push_back(v);
   endfunction

   function automatic logic [2:0] enc(input logic [7:0] g);
      enc = 3'd0;
      for (int k = 0; k < 8; k++) begin
         if (g[k]) enc = 3'(k);
      end
   endfunction

   initial begin
      vec_t ev;
      int   o;

      // T1: reset, single request, drop to idle (sel holds)
      add(1, 0, 8'h00, 8'h00, 3'd0, 0);
      add(1, 0, 8'h00, 8'h00, 3'd0, 0);
      add(1, 1, 8'h04, 8'h04, 3'd2, 1);
      add(1, 1, 8'h04, 8'h04, 3'd2, 1);
      add(1, 1, 8'h00, 8'h00, 3'd2, 0);
      add(1, 1, 8'h00, 8'h00, 3'd2, 0);

      // T2: fair rotation with all requesting, 4 cycles each
      add(2, 0, 8'h00, 8'h00, 3'd0, 0);
      for (int e = 1; e <= 33; e++) begin
         o = ((e - 1) / 4) % 8;
         add(2, 1, 8'hFF, 8'(1 << o), 3'(o), 1);
      end

      // T3: early release to 7, cnt restart, then back to 0, idle
      add(3, 0, 8'h00, 8'h00, 3'd0, 0);
      add(3, 1, 8'h81, 8'h01, 3'd0, 1);
      add(3, 1, 8'h81, 8'h01, 3'd0, 1);
      add(3, 1, 8'h80, 8'h80, 3'd7, 1);
      add(3, 1, 8'h81, 8'h80, 3'd7, 1);
      add(3, 1, 8'h81, 8'h80, 3'd7, 1);
      add(3, 1, 8'h81, 8'h80, 3'd7, 1);
      add(3, 1, 8'h81, 8'h01, 3'd0, 1);
      add(3, 1, 8'h00, 8'h00, 3'd0, 0);

      // T4: sole requester keeps grant through timeouts
      add(4, 0, 8'h00, 8'h00, 3'd0, 0);
      for (int e = 0; e < 12; e++) begin
         add(4, 1, 8'h20, 8'h20, 3'd5, 1);
      end
      add(4, 1, 8'h00, 8'h00, 3'd5, 0);

      // T5: pointer wrap 6 -> 0 -> 1, no preemption by non-owners
      add(5, 0, 8'h00, 8'h00, 3'd0, 0);
      add(5, 1, 8'h40, 8'h40, 3'd6, 1);
      add(5, 1, 8'h43, 8'h40, 3'd6, 1);
      add(5, 1, 8'h03, 8'h01, 3'd0, 1);
      add(5, 1, 8'h03, 8'h01, 3'd0, 1);
      add(5, 1, 8'h02, 8'h02, 3'd1, 1);
      add(5, 1, 8'h00, 8'h00, 3'd1, 0);

      // T6: reset during owner 3, then owner 0 first
      add(6, 0, 8'h00, 8'h00, 3'd0, 0);
      for (int e = 1; e <= 13; e++) begin
         o = (e - 1) / 4;
         add(6, 1, 8'hFF, 8'(1 << o), 3'(o), 1);
      end
      add(6, 0, 8'hFF, 8'h00, 3'd0, 0);
      add(6, 1, 8'hFF, 8'h01, 3'd0, 1);
      add(6, 1, 8'hFF, 8'h01, 3'd0, 1);

      for (int i = 0; i < vecs.size(); i++) begin
         rst_n = vecs[i].rst_n;
         req   = vecs[i].req;
         exp_q.push_back(vecs[i]);
         @(posedge clk);
         #1;
         ev = exp_q.pop_front();
         n_chk++;
         if (grant !== ev.g || sel !== ev.s || enable !== ev.e) begin
            n_fail++;
            $display("FAIL t%0d v%0d: got g=%h s=%0d en=%b want g=%h s=%0d en=%b",
                     ev.tid, i, grant, sel, enable, ev.g, ev.s, ev.e);
         end
         n_chk++;
         if ($countones(grant) > 1 || enable !== (|grant) ||
             (enable && sel !== enc(grant))) begin
            n_fail++;
            $display("FAIL inv v%0d: got g=%h s=%0d en=%b want onehot/consistent",
                     i, grant, sel, enable);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
